// File: rtl/l2_out_plane_arbiter.sv
// l2_out_plane_arbiter
// Merges the L2 response-out and forward-out channels onto one outgoing
// coherence response plane. Round-robin arbitration (one message per grant)
// feeds a DEPTH-entry FIFO whose head drives the plane. Each entry carries the
// payload plus a source bit (0 = rsp, 1 = fwd).
// Optional build macro L2_OUT_ARB_STATS_EN adds saturating 32-bit grant and
// full-cycle counters; arbitration is identical with or without it.
module l2_out_plane_arbiter #(
    parameter int COH_W  = 5,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int MASK_W = 4,
    parameter int DEPTH  = 4,
    parameter int PW     = COH_W + ID_W + 2 + ADDR_W + LINE_W + MASK_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    l2_rsp_out_valid,
    input  logic [PW-1:0]           l2_rsp_out_data,
    output logic                    l2_rsp_out_ready,
    input  logic                    l2_fwd_out_valid,
    input  logic [PW-1:0]           l2_fwd_out_data,
    output logic                    l2_fwd_out_ready,
    output logic                    plane_out_valid,
    output logic [PW-1:0]           plane_out_data,
    output logic                    plane_out_src,
    input  logic                    plane_out_ready,
    output logic [$clog2(DEPTH):0]  plane_out_count
`ifdef L2_OUT_ARB_STATS_EN
    ,
    output logic [31:0]             stat_rsp_grants,
    output logic [31:0]             stat_fwd_grants,
    output logic [31:0]             stat_full_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage: {src, payload}; payload storage is not reset, only control is.
    logic [PW:0]    mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           last_fwd;   // 1 = fwd was granted most recently

    logic           pop;
    logic           space;
    logic           grant_rsp;
    logic           grant_fwd;
    logic           push;
    logic           push_src;
    logic [PW-1:0]  push_data;

    // Arbitration and handshake decode; depends only on valids, plane ready and control state.
    always_comb begin
        pop       = plane_out_valid & plane_out_ready;
        space     = (count < FULL_CNT) | pop;
        grant_rsp = l2_rsp_out_valid & (~l2_fwd_out_valid | last_fwd);
        grant_fwd = l2_fwd_out_valid & (~l2_rsp_out_valid | ~last_fwd);
        l2_rsp_out_ready = ~rst & space & grant_rsp;
        l2_fwd_out_ready = ~rst & space & grant_fwd;
        push      = l2_rsp_out_ready | l2_fwd_out_ready;
        push_src  = l2_fwd_out_ready;
        push_data = l2_fwd_out_ready ? l2_fwd_out_data : l2_rsp_out_data;
    end

    // Control state: pointers, occupancy and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            last_fwd <= 1'b1;   // rsp wins the first contention after reset
        end else begin
            if (push) begin
                wptr     <= wptr + AW'(1);
                last_fwd <= push_src;
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO entry write; a push only lands in a free slot (or the one popping this cycle).
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {push_src, push_data};
        end
    end

    // Head presentation from registered storage; no bypass from the inputs.
    always_comb begin
        plane_out_valid = (count != '0);
        plane_out_src   = mem[rptr][PW];
        plane_out_data  = mem[rptr][PW-1:0];
        plane_out_count = count;
    end

`ifdef L2_OUT_ARB_STATS_EN
    logic [31:0] stat_rsp_q;
    logic [31:0] stat_fwd_q;
    logic [31:0] stat_full_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rsp_q  <= '0;
            stat_fwd_q  <= '0;
            stat_full_q <= '0;
        end else begin
            if (l2_rsp_out_ready) stat_rsp_q <= sat_inc(stat_rsp_q);
            if (l2_fwd_out_ready) stat_fwd_q <= sat_inc(stat_fwd_q);
            if ((count == FULL_CNT) && (l2_rsp_out_valid || l2_fwd_out_valid))
                stat_full_q <= sat_inc(stat_full_q);
        end
    end

    // Counter outputs.
    always_comb begin
        stat_rsp_grants  = stat_rsp_q;
        stat_fwd_grants  = stat_fwd_q;
        stat_full_cycles = stat_full_q;
    end
`endif

endmodule

// File: tb/tb_l2_out_plane_arbiter.sv
// Directed bench for l2_out_plane_arbiter (default parameters, DEPTH=4).
module tb_l2_out_plane_arbiter;

    localparam int PW = 5 + 4 + 2 + 28 + 128 + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rsp_v = 1'b0;
    logic [PW-1:0] rsp_d = '0;
    logic          rsp_r;
    logic          fwd_v = 1'b0;
    logic [PW-1:0] fwd_d = '0;
    logic          fwd_r;
    logic          o_valid;
    logic [PW-1:0] o_data;
    logic          o_src;
    logic          o_ready = 1'b0;
    logic [2:0]    o_count;
`ifdef L2_OUT_ARB_STATS_EN
    logic [31:0]   st_rsp;
    logic [31:0]   st_fwd;
    logic [31:0]   st_full;
`endif

    int total = 0;
    int bad   = 0;
    int n_rsp = 0;
    int n_fwd = 0;
    logic [PW-1:0] d1;

    always #5 clk = ~clk;

    l2_out_plane_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .l2_rsp_out_valid (rsp_v),
        .l2_rsp_out_data  (rsp_d),
        .l2_rsp_out_ready (rsp_r),
        .l2_fwd_out_valid (fwd_v),
        .l2_fwd_out_data  (fwd_d),
        .l2_fwd_out_ready (fwd_r),
        .plane_out_valid  (o_valid),
        .plane_out_data   (o_data),
        .plane_out_src    (o_src),
        .plane_out_ready  (o_ready),
        .plane_out_count  (o_count)
`ifdef L2_OUT_ARB_STATS_EN
        ,
        .stat_rsp_grants  (st_rsp),
        .stat_fwd_grants  (st_fwd),
        .stat_full_cycles (st_full)
`endif
    );

    // Distinct payload per tag: every field carries part of the tag.
    function automatic logic [PW-1:0] mk(input logic [7:0] t);
        return {t[4:0], t[3:0], t[1:0], 28'h0000200 + 28'(t), {16{t}}, t[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both valids high: readys must stay low.
        rsp_v = 1'b1; fwd_v = 1'b1;
        tick; tick;
        chk("rst_rsp_ready", 256'(rsp_r), 256'(0));
        chk("rst_fwd_ready", 256'(fwd_r), 256'(0));
        chk("rst_valid", 256'(o_valid), 256'(0));
        chk("rst_count", 256'(o_count), 256'(0));
        rsp_v = 1'b0; fwd_v = 1'b0; rst = 1'b0;
        tick;

        // Single rsp message.
        d1 = {5'h03, 4'h1, 2'b00, 28'h0000100, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 4'hF};
        rsp_v = 1'b1; rsp_d = d1;
        #1;
        chk("single_rsp_ready", 256'(rsp_r), 256'(1));
        chk("single_fwd_ready", 256'(fwd_r), 256'(0));
        chk("no_bypass_valid", 256'(o_valid), 256'(0));
        tick;
        rsp_v = 1'b0;
        chk("single_valid", 256'(o_valid), 256'(1));
        chk("single_data", 256'(o_data), 256'(d1));
        chk("single_src", 256'(o_src), 256'(0));
        chk("single_count", 256'(o_count), 256'(1));
        o_ready = 1'b1;
        tick;
        o_ready = 1'b0;
        chk("single_pop_count", 256'(o_count), 256'(0));
        chk("single_pop_valid", 256'(o_valid), 256'(0));

        // Fill to 3, then reset mid-operation.
        rsp_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rsp_d = mk(8'(i));
            tick;
        end
        rsp_v = 1'b0;
        chk("pre_rst_count", 256'(o_count), 256'(3));
        rst = 1'b1;
        tick;
        chk("mid_rst_valid", 256'(o_valid), 256'(0));
        chk("mid_rst_count", 256'(o_count), 256'(0));
        rst = 1'b0;
        tick;

        // Continuous contention with plane ready: rsp first, then alternate.
        rsp_v = 1'b1; fwd_v = 1'b1; o_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rsp_d = mk(8'(8'h10 + i));
            fwd_d = mk(8'(8'h20 + i));
            #1;
            chk("rr_rsp_ready", 256'(rsp_r), 256'((i % 2) == 0));
            chk("rr_fwd_ready", 256'(fwd_r), 256'((i % 2) == 1));
            if (i > 0) begin
                chk("rr_head_src", 256'(o_src), 256'(((i - 1) % 2) == 1));
                chk("rr_head_count", 256'(o_count), 256'(1));
            end
            n_rsp += int'(rsp_r);
            n_fwd += int'(fwd_r);
            tick;
        end
        rsp_v = 1'b0; fwd_v = 1'b0;
        chk("rr_rsp_total", 256'(n_rsp), 256'(4));
        chk("rr_fwd_total", 256'(n_fwd), 256'(4));
        chk("rr_end_count", 256'(o_count), 256'(1));
        chk("rr_last_data", 256'(o_data), 256'(mk(8'h27)));
        tick;
        o_ready = 1'b0;
        chk("rr_drained", 256'(o_count), 256'(0));

        // Fill with plane stalled: 4 accepted, 5th refused.
        rsp_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rsp_d = mk(8'(8'h40 + i));
            #1;
            chk("full_rsp_ready", 256'(rsp_r), 256'(i < 4));
            tick;
        end
        chk("full_count", 256'(o_count), 256'(4));
        o_ready = 1'b1;
        #1;
        chk("full_pop_push_ready", 256'(rsp_r), 256'(1));
        tick;
        rsp_v = 1'b0; o_ready = 1'b0;
        chk("full_pop_push_count", 256'(o_count), 256'(4));

        // Head stability under backpressure.
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("stall_data", 256'(o_data), 256'(mk(8'h41)));
            chk("stall_src", 256'(o_src), 256'(0));
        end

        // Drain in push order.
        o_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("drain_valid", 256'(o_valid), 256'(1));
            chk("drain_data", 256'(o_data), 256'(mk(8'(8'h40 + k))));
            tick;
        end
        o_ready = 1'b0;
        chk("drain_empty_valid", 256'(o_valid), 256'(0));
        chk("drain_empty_count", 256'(o_count), 256'(0));

`ifdef L2_OUT_ARB_STATS_EN
        rst = 1'b1;
        tick;
        rst = 1'b0;
        o_ready = 1'b1;
        rsp_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rsp_d = mk(8'(8'h60 + i));
            tick;
        end
        rsp_v = 1'b0; fwd_v = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fwd_d = mk(8'(8'h70 + i));
            tick;
        end
        fwd_v = 1'b0;
        chk("stat_rsp", 256'(st_rsp), 256'(3));
        chk("stat_fwd", 256'(st_fwd), 256'(2));
        dut.stat_rsp_q = 32'hFFFF_FFFE;
        rsp_v = 1'b1;
        tick; tick;
        rsp_v = 1'b0;
        chk("stat_rsp_sat", 256'(st_rsp), 256'(32'hFFFF_FFFF));
        tick; tick;
        o_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
